// File: rtl/stage_decode_if.sv
// Bundle between stage_decode and its neighbours: the fetched instruction and
// pipeline control coming in, the decoded instruction and hazard flag going out.
// The master side drives the fetch/control inputs; the slave side is the decoder.
interface stage_decode_if;
  logic [31:0] instr_addr_in;
  logic [31:0] instr_in;
  logic        flush;
  logic        stall;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;

  logic        hazard_stall;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [31:0] imm;
  logic [3:0]  alu_op;
  logic        alu_src_imm;
  logic        alu_src_pc;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        jump;
  logic        branch_en;
  logic [2:0]  branch_type;
  logic        illegal;

  modport master (
    output instr_addr_in, instr_in, flush, stall, ex_rd, ex_mem_read,
    input  hazard_stall, valid_out, pc_out, rs1_addr, rs2_addr, rd_addr, imm,
           alu_op, alu_src_imm, alu_src_pc, reg_write, mem_read, mem_write,
           jump, branch_en, branch_type, illegal
  );

  modport slave (
    input  instr_addr_in, instr_in, flush, stall, ex_rd, ex_mem_read,
    output hazard_stall, valid_out, pc_out, rs1_addr, rs2_addr, rd_addr, imm,
           alu_op, alu_src_imm, alu_src_pc, reg_write, mem_read, mem_write,
           jump, branch_en, branch_type, illegal
  );
endinterface

// File: rtl/stage_decode.sv
// RV32I decode stage: IF/ID pipeline register, instruction decode, immediate
// generation and load-use hazard detection against the instruction in execute.
// Decode works only from the registered instruction, so a bubble or a held
// instruction is decoded consistently regardless of what fetch presents.
module stage_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  stage_decode_if.slave bus
);

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;

  // IF/ID register
  logic        if_v_r;
  logic [31:0] if_pc_r;
  logic [31:0] if_ir_r;

  // Decoded fields and raw (ungated) controls
  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_s_s;
  logic [31:0] imm_b_s;
  logic [31:0] imm_u_s;
  logic [31:0] imm_j_s;
  logic [31:0] imm_sel_s;
  logic [3:0]  alu_op_s;
  logic        src_imm_s;
  logic        src_pc_s;
  logic        reg_write_s;
  logic        mem_read_s;
  logic        mem_write_s;
  logic        jump_s;
  logic        branch_s;
  logic        illegal_s;
  logic        use_rs1_s;
  logic        use_rs2_s;
  logic        rs1_zero_s;
  logic        hazard_s;
  logic        valid_s;

  assign opcode_s = if_ir_r[6:0];
  assign funct3_s = if_ir_r[14:12];

  assign imm_i_s = {{20{if_ir_r[31]}}, if_ir_r[31:20]};
  assign imm_s_s = {{20{if_ir_r[31]}}, if_ir_r[31:25], if_ir_r[11:7]};
  assign imm_b_s = {{19{if_ir_r[31]}}, if_ir_r[31], if_ir_r[7], if_ir_r[30:25],
                    if_ir_r[11:8], 1'b0};
  assign imm_u_s = {if_ir_r[31:12], 12'h000};
  assign imm_j_s = {{11{if_ir_r[31]}}, if_ir_r[31], if_ir_r[19:12], if_ir_r[20],
                    if_ir_r[30:21], 1'b0};

  // Per-opcode control decode of the registered instruction
  always_comb begin
    imm_sel_s   = 32'h0000_0000;
    alu_op_s    = 4'b0000;
    src_imm_s   = 1'b0;
    src_pc_s    = 1'b0;
    reg_write_s = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    jump_s      = 1'b0;
    branch_s    = 1'b0;
    illegal_s   = 1'b0;
    use_rs1_s   = 1'b1;
    use_rs2_s   = 1'b0;
    rs1_zero_s  = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        reg_write_s = 1'b1;
        alu_op_s    = {if_ir_r[30], funct3_s};
        use_rs2_s   = 1'b1;
      end
      OPC_OP_IMM: begin
        reg_write_s = 1'b1;
        src_imm_s   = 1'b1;
        imm_sel_s   = imm_i_s;
        // Only shifts use bit 30 to pick SRAI over SRLI; elsewhere it is immediate data
        if (funct3_s == 3'b101) begin
          alu_op_s = {if_ir_r[30], funct3_s};
        end else begin
          alu_op_s = {1'b0, funct3_s};
        end
      end
      OPC_LOAD: begin
        reg_write_s = 1'b1;
        mem_read_s  = 1'b1;
        src_imm_s   = 1'b1;
        imm_sel_s   = imm_i_s;
      end
      OPC_STORE: begin
        mem_write_s = 1'b1;
        src_imm_s   = 1'b1;
        imm_sel_s   = imm_s_s;
        use_rs2_s   = 1'b1;
      end
      OPC_BRANCH: begin
        branch_s  = 1'b1;
        imm_sel_s = imm_b_s;
        use_rs2_s = 1'b1;
      end
      OPC_JAL: begin
        reg_write_s = 1'b1;
        jump_s      = 1'b1;
        src_pc_s    = 1'b1;
        imm_sel_s   = imm_j_s;
        use_rs1_s   = 1'b0;
      end
      OPC_JALR: begin
        reg_write_s = 1'b1;
        jump_s      = 1'b1;
        src_imm_s   = 1'b1;
        imm_sel_s   = imm_i_s;
      end
      OPC_LUI: begin
        reg_write_s = 1'b1;
        src_imm_s   = 1'b1;
        imm_sel_s   = imm_u_s;
        use_rs1_s   = 1'b0;
        rs1_zero_s  = 1'b1;
      end
      OPC_AUIPC: begin
        reg_write_s = 1'b1;
        src_pc_s    = 1'b1;
        src_imm_s   = 1'b1;
        imm_sel_s   = imm_u_s;
        use_rs1_s   = 1'b0;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  // Load-use hazard: the load in execute writes a register this instruction reads
  assign hazard_s = if_v_r & bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                    ((use_rs1_s & (bus.ex_rd == if_ir_r[19:15])) |
                     (use_rs2_s & (bus.ex_rd == if_ir_r[24:20])));
  assign valid_s  = if_v_r & ~hazard_s;

  // IF/ID register update: reset, then flush, then hold on any stall, else load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_v_r  <= 1'b0;
      if_pc_r <= RESET_PC;
      if_ir_r <= NOP;
    end else if (bus.flush) begin
      if_v_r  <= 1'b0;
      if_pc_r <= if_pc_r;
      if_ir_r <= NOP;
    end else if (bus.stall | hazard_s) begin
      if_v_r  <= if_v_r;
      if_pc_r <= if_pc_r;
      if_ir_r <= if_ir_r;
    end else begin
      if_v_r  <= 1'b1;
      if_pc_r <= bus.instr_addr_in;
      if_ir_r <= bus.instr_in;
    end
  end

  // Field outputs follow the register; every control is suppressed for a bubble
  assign bus.hazard_stall = hazard_s;
  assign bus.valid_out    = valid_s;
  assign bus.pc_out       = if_pc_r;
  assign bus.rs1_addr     = rs1_zero_s ? 5'd0 : if_ir_r[19:15];
  assign bus.rs2_addr     = if_ir_r[24:20];
  assign bus.rd_addr      = if_ir_r[11:7];
  assign bus.imm          = imm_sel_s;
  assign bus.alu_op       = valid_s ? alu_op_s : 4'b0000;
  assign bus.alu_src_imm  = valid_s & src_imm_s;
  assign bus.alu_src_pc   = valid_s & src_pc_s;
  assign bus.reg_write    = valid_s & reg_write_s;
  assign bus.mem_read     = valid_s & mem_read_s;
  assign bus.mem_write    = valid_s & mem_write_s;
  assign bus.jump         = valid_s & jump_s;
  assign bus.branch_en    = valid_s & branch_s;
  assign bus.branch_type  = (valid_s & branch_s) ? funct3_s : 3'b000;
  assign bus.illegal      = valid_s & illegal_s;

endmodule

// File: tb/tb_stage_decode.sv
// Scoreboard bench for stage_decode: the driver advances an architectural
// model of the IF/ID register and pushes the expected decode for every cycle;
// a monitor on the falling edge pops and compares against the DUT.
module tb_stage_decode;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        hz;
    logic        vo;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        src_imm;
    logic        src_pc;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        jmp;
    logic        br;
    logic [2:0]  bt;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stage_decode_if bus ();
  stage_decode #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   checks   = 0;
  int   failures = 0;
  logic mon_en   = 1'b0;
  exp_t q[$];
  exp_t mon_e;

  // Architectural model of IF/ID plus the inputs in effect at the next edge
  logic        m_v, m_flush, m_stall, m_hz;
  logic [31:0] m_pc, m_ir, m_addr, m_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] sx12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  // Reference decode written straight from the opcode table
  function automatic exp_t ref_decode(input logic v, input logic [31:0] pc,
                                      input logic [31:0] ir, input logic [4:0] er,
                                      input logic emr);
    exp_t e;
    logic reads1, reads2;
    logic [2:0] f3;
    f3 = ir[14:12];
    e = '{hz:1'b0, vo:1'b0, pc:pc, imm:32'h0, rs1:ir[19:15], rs2:ir[24:20],
          rd:ir[11:7], alu_op:4'h0, src_imm:1'b0, src_pc:1'b0, rw:1'b0, mr:1'b0,
          mw:1'b0, jmp:1'b0, br:1'b0, bt:3'b000, ill:1'b0};
    reads1 = 1'b1;
    reads2 = 1'b0;
    case (ir[6:0])
      7'b0110011: begin e.rw = 1'b1; e.alu_op = {ir[30], f3}; reads2 = 1'b1; end
      7'b0010011: begin
        e.rw = 1'b1; e.src_imm = 1'b1; e.imm = sx12(ir[31:20]);
        e.alu_op = {(f3 == 3'b101) ? ir[30] : 1'b0, f3};
      end
      7'b0000011: begin e.rw = 1'b1; e.mr = 1'b1; e.src_imm = 1'b1; e.imm = sx12(ir[31:20]); end
      7'b0100011: begin
        e.mw = 1'b1; e.src_imm = 1'b1; e.imm = sx12({ir[31:25], ir[11:7]}); reads2 = 1'b1;
      end
      7'b1100011: begin
        e.br = 1'b1; e.bt = f3; reads2 = 1'b1;
        e.imm = 32'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
      end
      7'b1101111: begin
        e.rw = 1'b1; e.jmp = 1'b1; e.src_pc = 1'b1; reads1 = 1'b0;
        e.imm = 32'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
      end
      7'b1100111: begin e.rw = 1'b1; e.jmp = 1'b1; e.src_imm = 1'b1; e.imm = sx12(ir[31:20]); end
      7'b0110111: begin
        e.rw = 1'b1; e.src_imm = 1'b1; e.imm = {ir[31:12], 12'h000}; e.rs1 = 5'd0; reads1 = 1'b0;
      end
      7'b0010111: begin
        e.rw = 1'b1; e.src_pc = 1'b1; e.src_imm = 1'b1; e.imm = {ir[31:12], 12'h000}; reads1 = 1'b0;
      end
      default: e.ill = 1'b1;
    endcase
    e.hz = v && emr && (er != 5'd0) &&
           ((reads1 && er == ir[19:15]) || (reads2 && er == ir[24:20]));
    e.vo = v && !e.hz;
    if (!e.vo) begin
      e.alu_op = 4'h0; e.src_imm = 1'b0; e.src_pc = 1'b0; e.rw = 1'b0; e.mr = 1'b0;
      e.mw = 1'b0; e.jmp = 1'b0; e.br = 1'b0; e.bt = 3'b000; e.ill = 1'b0;
    end
    return e;
  endfunction

  // One clock: advance the model over the edge, drive new inputs, push expectation
  task automatic cycle(input logic [31:0] a, input logic [31:0] i, input logic f,
                       input logic s, input logic [4:0] er, input logic emr);
    exp_t e;
    @(posedge clk);
    if (m_flush) begin
      m_v = 1'b0; m_ir = NOP;
    end else if (!(m_stall || m_hz)) begin
      m_v = 1'b1; m_pc = m_addr; m_ir = m_instr;
    end
    #1;
    bus.instr_addr_in = a; bus.instr_in = i; bus.flush = f; bus.stall = s;
    bus.ex_rd = er; bus.ex_mem_read = emr;
    m_addr = a; m_instr = i; m_flush = f; m_stall = s;
    e = ref_decode(m_v, m_pc, m_ir, er, emr);
    m_hz = e.hz;
    q.push_back(e);
    mon_en = 1'b1;
  endtask

  // Asynchronous reset asserted between edges, with immediate output checks
  task automatic do_reset();
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_valid_out", {31'd0, bus.valid_out}, 32'd0);
    chk("rst_pc_out", bus.pc_out, 32'h0000_0000);
    chk("rst_hazard", {31'd0, bus.hazard_stall}, 32'd0);
    chk("rst_ctrl", {24'd0, bus.reg_write, bus.mem_read, bus.mem_write, bus.jump,
                     bus.branch_en, bus.illegal, bus.alu_src_imm, bus.alu_src_pc}, 32'd0);
    chk("rst_rd", {27'd0, bus.rd_addr}, 32'd0);
    chk("rst_imm", bus.imm, 32'd0);
    q.delete();
    bus.instr_addr_in = 32'h0000_0100; bus.instr_in = 32'h0010_0093;
    bus.flush = 1'b0; bus.stall = 1'b0; bus.ex_rd = 5'd0; bus.ex_mem_read = 1'b0;
    m_v = 1'b0; m_pc = 32'h0; m_ir = NOP; m_hz = 1'b0;
    m_addr = bus.instr_addr_in; m_instr = bus.instr_in; m_flush = 1'b0; m_stall = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [6:0] opcs [0:12];
    logic [31:0] w;
    opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
             7'b1100111, 7'b0110111, 7'b0010111, 7'h0F, 7'h73, 7'h7F, 7'h5B};
    w = $urandom;
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    w[6:0] = opcs[$urandom_range(0, 12)];
    return w;
  endfunction

  // Monitor: compare every presented cycle against the scoreboard head
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty actual=output required=expectation at %0t", $time);
      end else begin
        mon_e = q.pop_front();
        chk("hazard_stall", {31'd0, bus.hazard_stall}, {31'd0, mon_e.hz});
        chk("valid_out", {31'd0, bus.valid_out}, {31'd0, mon_e.vo});
        chk("pc_out", bus.pc_out, mon_e.pc);
        chk("imm", bus.imm, mon_e.imm);
        chk("regs", {17'd0, bus.rs1_addr, bus.rs2_addr, bus.rd_addr},
            {17'd0, mon_e.rs1, mon_e.rs2, mon_e.rd});
        chk("alu", {26'd0, bus.alu_op, bus.alu_src_imm, bus.alu_src_pc},
            {26'd0, mon_e.alu_op, mon_e.src_imm, mon_e.src_pc});
        chk("ctrl", {23'd0, bus.reg_write, bus.mem_read, bus.mem_write, bus.jump,
                     bus.branch_en, bus.branch_type, bus.illegal},
            {23'd0, mon_e.rw, mon_e.mr, mon_e.mw, mon_e.jmp, mon_e.br, mon_e.bt, mon_e.ill});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_addr_in = 32'h0; bus.instr_in = NOP; bus.flush = 1'b0; bus.stall = 1'b0;
    bus.ex_rd = 5'd0; bus.ex_mem_read = 1'b0;
    do_reset();

    // ADDI x5, x1, -3 at 0x10
    cycle(32'h10, 32'hFFD0_8293, 1'b0, 1'b0, 5'd0, 1'b0);
    cycle(32'h14, 32'hFE20_8CE3, 1'b0, 1'b0, 5'd0, 1'b0);
    #3;
    chk("addi_valid", {31'd0, bus.valid_out}, 32'd1);
    chk("addi_pc", bus.pc_out, 32'h10);
    chk("addi_rs1_rd", {22'd0, bus.rs1_addr, bus.rd_addr}, {22'd0, 5'd1, 5'd5});
    chk("addi_imm", bus.imm, 32'hFFFF_FFFD);
    chk("addi_ctrl", {26'd0, bus.alu_op, bus.alu_src_imm, bus.reg_write}, {26'd0, 4'b0000, 1'b1, 1'b1});

    // Branch BEQ x1, x2, -8
    cycle(32'h20, 32'h0011_8233, 1'b0, 1'b0, 5'd0, 1'b0);
    #3;
    chk("br_regs", {22'd0, bus.rs1_addr, bus.rs2_addr}, {22'd0, 5'd1, 5'd2});
    chk("br_imm", bus.imm, 32'hFFFF_FFF8);
    chk("br_ctrl", {27'd0, bus.branch_en, bus.branch_type, bus.reg_write}, {27'd0, 1'b1, 3'b000, 1'b0});

    // Load-use: ADD x4, x3, x1 in IF/ID with a load to x3 in execute
    cycle(32'h24, 32'h0000_0013, 1'b0, 1'b0, 5'd3, 1'b1);
    #3;
    chk("lu_hazard", {31'd0, bus.hazard_stall}, 32'd1);
    chk("lu_bubble", {31'd0, bus.valid_out}, 32'd0);
    cycle(32'h24, 32'h0000_0013, 1'b0, 1'b0, 5'd0, 1'b0);
    #3;
    chk("lu_release", {31'd0, bus.valid_out, bus.hazard_stall}, {30'd0, 1'b1, 1'b0});
    chk("lu_same_pc", bus.pc_out, 32'h20);

    // Flush together with stall
    cycle(32'h30, 32'hFFD0_8293, 1'b1, 1'b1, 5'd0, 1'b0);
    cycle(32'h34, 32'h0000_007F, 1'b0, 1'b0, 5'd0, 1'b0);
    #3;
    chk("fl_bubble", {30'd0, bus.valid_out, bus.reg_write}, 32'd0);
    cycle(32'h38, 32'h0000_0013, 1'b0, 1'b0, 5'd0, 1'b0);
    #3;
    chk("fl_load_pc", bus.pc_out, 32'h34);
    chk("ill_ctrl", {29'd0, bus.illegal, bus.reg_write, bus.mem_write}, {29'd0, 1'b1, 1'b0, 1'b0});

    // Randomized traffic with one reset in the middle of the stream
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      cycle($urandom & 32'hFFFF_FFFC, gen_instr(), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 4) == 0), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0));
    end

    cycle(32'h0, NOP, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_decode.md
# stage_decode

Second stage of the in-order RV32I core, directly downstream of `stage_fetch`. It holds the IF/ID pipeline register, capturing `instr`/`instr_addr` each cycle. It decodes the registered instruction into register addresses, a sign-extended immediate and control signals for execute. It also handles flushes on taken branches, external stalls, and load-use hazard detection against the instruction in execute.

## Interface
- `RESET_PC`, default 32'h0000_0000: value loaded into the registered PC on reset.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous, active-high.
- `instr_addr_in` in 32: PC of the fetched instruction, driven by `stage_fetch`.
- `instr_in` in 32: fetched instruction word.
- `flush` in 1: taken branch/jump resolved downstream; discard the IF/ID contents.
- `stall` in 1: downstream stall; hold the IF/ID contents.
- `ex_rd` in 5: destination register of the instruction currently in execute.
- `ex_mem_read` in 1: the instruction in execute is a load.
- `hazard_stall` out 1: load-use hazard detected; fetch must hold its PC.
- `valid_out` out 1: the decoded outputs describe a real instruction (0 = bubble).
- `pc_out` out 32: PC of the decoded instruction.
- `rs1_addr`, `rs2_addr`, `rd_addr` out 5 each: register fields.
- `imm` out 32: sign-extended immediate.
- `alu_op` out 4: ALU operation, encoded as {funct7[5], funct3}.
- `alu_src_imm` out 1: operand B is `imm`.
- `alu_src_pc` out 1: operand A is `pc_out`.
- `reg_write`, `mem_read`, `mem_write`, `jump`, `branch_en` out 1 each.
- `branch_type` out 3: funct3 of the branch.
- `illegal` out 1: unsupported opcode.

## Operation
- IF/ID register fields: `v`, `pc`, `ir`.
- Update priority per rising edge:
  1. `rst`: v=0, pc=RESET_PC, ir=32'h0000_0013 (NOP).
  2. `flush`: v=0, ir=NOP. Flush overrides all stalls.
  3. `stall | hazard_stall`: hold all fields.
  4. Otherwise: load v=1, pc=`instr_addr_in`, ir=`instr_in`.
- `hazard_stall` = v & `ex_mem_read` & (`ex_rd`≠0) & (`ex_rd`==rs1 | (uses_rs2 & `ex_rd`==rs2)).
  - uses_rs2 holds for R-type, store and branch opcodes.
  - rs1 is compared for every opcode except LUI, AUIPC and JAL.
- `valid_out` = v & ~`hazard_stall`. During a hazard, execute receives a bubble.
- When `valid_out`=0 (bubble), `reg_write`, `mem_read`, `mem_write`, `jump`, `branch_en` and `illegal` are forced to 0.
- Decode is combinational from the IF/ID register only, never from `instr_in`.
- Immediates, sign-extended from bit 31:
  - I: ir[31:20].
  - S: {ir[31:25], ir[11:7]}.
  - B: {ir[31], ir[7], ir[30:25], ir[11:8], 0}.
  - U: {ir[31:12], 12'b0}.
  - J: {ir[31], ir[19:12], ir[20], ir[30:21], 0}.
- Per-opcode controls:
  - OP (0110011): reg_write; alu_op={ir[30], funct3}.
  - OP-IMM (0010011): reg_write, alu_src_imm; alu_op={funct3==101 ? ir[30] : 0, funct3}.
  - LOAD (0000011): reg_write, mem_read, alu_src_imm; alu_op=ADD (0000).
  - STORE (0100011): mem_write, alu_src_imm; ADD.
  - BRANCH (1100011): branch_en; branch_type=funct3; B-immediate.
  - JAL (1101111): reg_write, jump, alu_src_pc; J-immediate.
  - JALR (1100111): reg_write, jump, alu_src_imm.
  - LUI (0110111): reg_write, alu_src_imm; `rs1_addr` forced to 0; ADD.
  - AUIPC (0010111): reg_write, alu_src_pc, alu_src_imm; ADD.
  - Any other opcode: `illegal`=1 when v=1; all write/mem controls 0.

## Timing
- Latency: an instruction presented at edge N is decoded during cycle N→N+1.
- Reset values (asynchronous, immediate): `valid_out`=0, `pc_out`=RESET_PC, `hazard_stall`=0.
  - All control outputs are 0.
  - Field outputs reflect the decoded NOP: `rd_addr`=0, `imm`=0.
- `hazard_stall` is combinational, same cycle as the hazard.
  - It clears the cycle after execute no longer holds the load.
  - Typical duration: exactly 1 cycle.
- `flush` and `stall` in the same cycle: flush wins.
  - The next cycle shows `valid_out`=0, and the hazard is cleared.
- `rst` released mid-stream: the first valid instruction appears one edge after the first non-reset edge.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> outputs go to reset values immediately (`valid_out`=0, `pc_out`=0).
- ADDI: `instr_in`=32'hFFD08293, `instr_addr_in`=0x10 -> next cycle `valid_out`=1, `pc_out`=0x10, rs1=1, rd=5, `imm`=0xFFFFFFFD, `alu_op`=0000, `alu_src_imm`=1, `reg_write`=1.
- Branch: `instr_in`=32'hFE208CE3 -> rs1=1, rs2=2, `imm`=0xFFFFFFF8, `branch_en`=1, `branch_type`=000, `reg_write`=0.
- Load-use: IF/ID holds 32'h00118233, `ex_rd`=3, `ex_mem_read`=1 -> `hazard_stall`=1, `valid_out`=0, IF/ID held.
  - Next cycle with `ex_mem_read`=0 -> `valid_out`=1, same PC.
- Flush vs stall: assert `flush` and `stall` together -> next cycle `valid_out`=0, `reg_write`=0.
  - Following cycle loads the new `instr_in`.
- Illegal: `instr_in`=32'h0000007F -> `illegal`=1, `reg_write`=`mem_write`=0.
